// File: rtl/dm_cache_wb_if.sv
// CPU-side and memory-side bus of the direct-mapped write-back cache.
// The master modport is the CPU/memory environment and the slave modport is the cache.
interface dm_cache_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int OFF_W  = 2,
  parameter int CNT_W  = 16
);
  localparam int LINE_W = DATA_W * (2 ** OFF_W);

  logic                    cpu_rd;
  logic                    cpu_wr;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_wdata;
  logic [DATA_W-1:0]       cpu_rdata;
  logic                    stall;

  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-OFF_W-1:0] mem_addr;
  logic [LINE_W-1:0]       mem_wdata;
  logic [LINE_W-1:0]       mem_rdata;
  logic                    mem_ready;

  logic [CNT_W-1:0]        hit_count;
  logic [CNT_W-1:0]        miss_count;

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata,
           hit_count, miss_count
  );
endinterface

// File: rtl/dm_cache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide
// memory handshake, an internal miss FSM and saturating hit/miss counters.
module dm_cache_wb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 5,
  parameter int OFF_W   = 2,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          RST,
  dm_cache_wb_if.slave bus
);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int LINE_W = DATA_W * (2 ** OFF_W);
  localparam int NLINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;

  logic [NLINES-1:0]            r_valid;
  logic [NLINES-1:0]            r_dirty;
  logic [NLINES-1:0][TAG_W-1:0] r_tag;
  logic [LINE_W-1:0]            r_data [NLINES];

  logic [CNT_W-1:0]             r_hit_cnt;
  logic [CNT_W-1:0]             r_miss_cnt;
  logic                         r_retry;

  logic [OFF_W-1:0]             w_off;
  logic [INDEX_W-1:0]           w_idx;
  logic [TAG_W-1:0]             w_tag;
  logic                         w_req;
  logic                         w_hit;
  logic                         w_idle;
  logic                         w_wr_hit;
  logic                         w_refill_done;
  logic [LINE_W-1:0]            w_line;
  logic [DATA_W-1:0]            w_word;

  logic                         w_mem_req;
  logic                         w_mem_we;
  logic [ADDR_W-OFF_W-1:0]      w_mem_addr;
  logic [LINE_W-1:0]            w_mem_wdata;

  assign w_off  = bus.cpu_addr[OFF_W-1:0];
  assign w_idx  = bus.cpu_addr[OFF_W +: INDEX_W];
  assign w_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_req  = bus.cpu_rd | bus.cpu_wr;
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_idle = (r_state == IDLE);
  assign w_line = r_data[w_idx];
  assign w_word = w_line[w_off*DATA_W +: DATA_W];

  // A store wins over a simultaneous load, so the load data is suppressed then.
  assign w_wr_hit      = !RST && w_idle && bus.cpu_wr && w_hit;
  assign w_refill_done = !RST && (r_state == REFILL) && bus.mem_ready;

  assign bus.stall     = !RST && ((w_req && !w_hit && w_idle) || !w_idle);
  assign bus.cpu_rdata = (!RST && w_idle && bus.cpu_rd && !bus.cpu_wr && w_hit) ?
                         w_word : '0;

  assign bus.mem_req    = w_mem_req;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;

  // Miss sequencing: evict a dirty victim first, then fetch the requested line.
  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          w_state_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {r_tag[w_idx], w_idx};
        w_mem_wdata = w_line;
        if (bus.mem_ready) begin
          w_state_next = REFILL;
        end
      end
      REFILL: begin
        w_mem_req  = 1'b1;
        w_mem_addr = {w_tag, w_idx};
        if (bus.mem_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The retry flag keeps the replayed access after a refill out of the hit count.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_tag      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_retry    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_refill_done) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
        r_tag[w_idx]   <= w_tag;
        r_retry        <= 1'b1;
      end else if (w_idle) begin
        r_retry <= 1'b0;
      end
      if (w_idle && w_req && w_hit && !r_retry && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (w_idle && w_req && !w_hit && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_refill_done) begin
      r_data[w_idx] <= bus.mem_rdata;
    end else if (w_wr_hit) begin
      r_data[w_idx][w_off*DATA_W +: DATA_W] <= bus.cpu_wdata;
    end
  end
endmodule

// File: tb/tb_dm_cache_wb.sv
// Testbench for dm_cache_wb: directed scenarios plus randomized accesses
// checked against a word-level reference model of cache and memory.
module tb_dm_cache_wb;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 10;
  localparam int INDEX_W = 5;
  localparam int OFF_W   = 2;
  localparam int CNT_W   = 4;
  localparam int LINE_W  = 128;
  localparam int NLINES  = 32;
  localparam int NMEM    = 256;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  dm_cache_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

  dm_cache_wb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFF_W(OFF_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  // Reference state: memory as words, cache as word arrays with valid/dirty/tag.
  logic [31:0]       refMem [NMEM][4];
  logic [LINE_W-1:0] memLines [NMEM];
  bit                refValid [NLINES];
  bit                refDirty [NLINES];
  int                refTag [NLINES];
  logic [31:0]       refData [NLINES][4];
  int                refHits, refMisses;

  bit                expMiss, expWb;
  int                expWbAddr, expRfAddr;
  logic [LINE_W-1:0] expWbLine;
  logic [31:0]       expRdata;

  bit                obsFirstStall, obsTimeout;
  int                obsNTx, obsCycles;
  logic              obsTxWe [4];
  logic [7:0]        obsTxAddr [4];
  logic [LINE_W-1:0] obsTxLine [4];
  logic [31:0]       obsRdata;

  int nVectors = 0;
  int nMiscompares = 0;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic refReset();
    for (int i = 0; i < NLINES; i++) begin
      refValid[i] = 0;
      refDirty[i] = 0;
      refTag[i]   = 0;
    end
    refHits   = 0;
    refMisses = 0;
  endtask

  task automatic refAccess(input bit rd, input bit wr, input logic [9:0] addr, input logic [31:0] wdata);
    int idx, tag, off;
    idx = (int'(addr) / 4) % NLINES;
    tag = int'(addr) / 128;
    off = int'(addr) % 4;
    expMiss = 0; expWb = 0; expRdata = '0; expWbAddr = 0; expRfAddr = 0; expWbLine = '0;
    if (!(refValid[idx] && refTag[idx] == tag)) begin
      expMiss = 1;
      refMisses++;
      if (refValid[idx] && refDirty[idx]) begin
        expWb = 1;
        expWbAddr = refTag[idx] * NLINES + idx;
        for (int w = 0; w < 4; w++) begin
          expWbLine[w*32 +: 32] = refData[idx][w];
          refMem[expWbAddr][w]  = refData[idx][w];
        end
      end
      expRfAddr = tag * NLINES + idx;
      for (int w = 0; w < 4; w++) refData[idx][w] = refMem[expRfAddr][w];
      refValid[idx] = 1;
      refDirty[idx] = 0;
      refTag[idx]   = tag;
    end else begin
      refHits++;
    end
    if (wr) begin
      refData[idx][off] = wdata;
      refDirty[idx] = 1;
    end else if (rd) begin
      expRdata = refData[idx][off];
    end
  endtask

  // Drives one CPU access and plays the memory side until the cache stops stalling.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [9:0] addr,
                               input logic [31:0] wdata, input int delay);
    bit done, newTx;
    int waitCnt;
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    obsNTx = 0; obsTimeout = 0; obsCycles = 0; obsRdata = '0; obsFirstStall = 0;
    done = 0; newTx = 1; waitCnt = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (cyc == 0) obsFirstStall = bus.stall;
      if (!bus.stall) begin
        obsRdata  = bus.cpu_rdata;
        obsCycles = cyc + 1;
        done = 1;
      end else if (bus.mem_req) begin
        if (newTx) begin
          if (obsNTx < 4) begin
            obsTxWe[obsNTx]   = bus.mem_we;
            obsTxAddr[obsNTx] = bus.mem_addr;
            obsTxLine[obsNTx] = bus.mem_wdata;
          end
          obsNTx++;
          newTx = 0;
          waitCnt = 0;
        end
        if (!bus.mem_we) bus.mem_rdata = memLines[bus.mem_addr];
        if (waitCnt >= delay) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) memLines[bus.mem_addr] = bus.mem_wdata;
          newTx = 1;
        end else begin
          waitCnt++;
        end
      end
      @(posedge clk); #1;
    end
    if (!done) obsTimeout = 1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 10'h085; bus.cpu_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    nVectors++; if (bus.stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
    nVectors++; if (bus.cpu_rdata !== 32'h0) begin nMiscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.cpu_rdata); end
    nVectors++; if (bus.mem_req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
    nVectors++; if (bus.hit_count !== 4'd0 || bus.miss_count !== 4'd0) begin nMiscompares++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", bus.hit_count, bus.miss_count); end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    RST = 1'b0;
    refReset();
  endtask

  task automatic test_clean_read_miss();
    memLines[8'h21] = {32'h33, 32'h22, 32'h11, 32'h00};
    refMem[8'h21][0] = 32'h00; refMem[8'h21][1] = 32'h11; refMem[8'h21][2] = 32'h22; refMem[8'h21][3] = 32'h33;
    refAccess(1, 0, 10'h085, '0);
    applyStimulus(1, 0, 10'h085, '0, 3);
    nVectors++; if (obsTimeout) begin nMiscompares++; $display("[TB] FAIL t1_timeout: got timeout expected completion"); end
    nVectors++; if (obsFirstStall !== 1'b1) begin nMiscompares++; $display("[TB] FAIL t1_stall: got %b expected 1", obsFirstStall); end
    nVectors++; if (obsNTx !== 1 || obsTxWe[0] !== 1'b0 || obsTxAddr[0] !== 8'h21) begin nMiscompares++; $display("[TB] FAIL t1_refill: got n=%0d we=%b addr=%h expected n=1 we=0 addr=21", obsNTx, obsTxWe[0], obsTxAddr[0]); end
    nVectors++; if (obsRdata !== 32'h11) begin nMiscompares++; $display("[TB] FAIL t1_rdata: got %h expected 11", obsRdata); end
    nVectors++; if (obsCycles !== 6) begin nMiscompares++; $display("[TB] FAIL t1_latency: got %0d expected 6", obsCycles); end
    nVectors++; if (bus.miss_count !== 4'd1 || bus.hit_count !== 4'd0) begin nMiscompares++; $display("[TB] FAIL t1_counters: got %0d/%0d expected 0/1", bus.hit_count, bus.miss_count); end
  endtask

  task automatic test_read_hits();
    refAccess(1, 0, 10'h084, '0);
    applyStimulus(1, 0, 10'h084, '0, 0);
    nVectors++; if (obsFirstStall !== 1'b0 || obsRdata !== 32'h00) begin nMiscompares++; $display("[TB] FAIL t2_hit0: got stall=%b rdata=%h expected 0/00", obsFirstStall, obsRdata); end
    refAccess(1, 0, 10'h087, '0);
    applyStimulus(1, 0, 10'h087, '0, 0);
    nVectors++; if (obsFirstStall !== 1'b0 || obsRdata !== 32'h33) begin nMiscompares++; $display("[TB] FAIL t2_hit3: got stall=%b rdata=%h expected 0/33", obsFirstStall, obsRdata); end
    nVectors++; if (bus.hit_count !== 4'd2) begin nMiscompares++; $display("[TB] FAIL t2_hit_count: got %0d expected 2", bus.hit_count); end
  endtask

  task automatic test_dirty_eviction();
    refAccess(0, 1, 10'h086, 32'hDEADBEEF);
    applyStimulus(0, 1, 10'h086, 32'hDEADBEEF, 0);
    nVectors++; if (obsFirstStall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL t3_wr_stall: got %b expected 0", obsFirstStall); end
    refAccess(1, 0, 10'h105, '0);
    applyStimulus(1, 0, 10'h105, '0, 1);
    nVectors++; if (obsNTx !== 2) begin nMiscompares++; $display("[TB] FAIL t3_ntx: got %0d expected 2", obsNTx); end
    nVectors++; if (obsTxWe[0] !== 1'b1 || obsTxAddr[0] !== 8'h21) begin nMiscompares++; $display("[TB] FAIL t3_wb_addr: got we=%b addr=%h expected 1/21", obsTxWe[0], obsTxAddr[0]); end
    nVectors++; if (obsTxLine[0] !== {32'h33, 32'hDEADBEEF, 32'h11, 32'h00}) begin nMiscompares++; $display("[TB] FAIL t3_wb_data: got %h expected %h", obsTxLine[0], {32'h33, 32'hDEADBEEF, 32'h11, 32'h00}); end
    nVectors++; if (obsTxWe[1] !== 1'b0 || obsTxAddr[1] !== 8'h41) begin nMiscompares++; $display("[TB] FAIL t3_refill: got we=%b addr=%h expected 0/41", obsTxWe[1], obsTxAddr[1]); end
    nVectors++; if (obsRdata !== expRdata || obsCycles !== 6) begin nMiscompares++; $display("[TB] FAIL t3_rdata_latency: got %h/%0d expected %h/6", obsRdata, obsCycles, expRdata); end
    nVectors++; if (bus.miss_count !== 4'd2) begin nMiscompares++; $display("[TB] FAIL t3_miss_count: got %0d expected 2", bus.miss_count); end
  endtask

  task automatic test_write_allocate_top_index();
    refAccess(0, 1, 10'h3FC, 32'h5A5A5A5A);
    applyStimulus(0, 1, 10'h3FC, 32'h5A5A5A5A, 2);
    nVectors++; if (obsNTx !== 1 || obsTxWe[0] !== 1'b0 || obsTxAddr[0] !== 8'hFF) begin nMiscompares++; $display("[TB] FAIL t4_refill_only: got n=%0d we=%b addr=%h expected 1/0/ff", obsNTx, obsTxWe[0], obsTxAddr[0]); end
    refAccess(1, 0, 10'h3FC, '0);
    applyStimulus(1, 0, 10'h3FC, '0, 0);
    nVectors++; if (obsFirstStall !== 1'b0 || obsRdata !== 32'h5A5A5A5A) begin nMiscompares++; $display("[TB] FAIL t4_readback: got stall=%b rdata=%h expected 0/5a5a5a5a", obsFirstStall, obsRdata); end
    refAccess(1, 0, 10'h07C, '0);
    applyStimulus(1, 0, 10'h07C, '0, 0);
    nVectors++; if (obsNTx !== 2 || obsTxWe[0] !== 1'b1 || obsTxAddr[0] !== 8'hFF) begin nMiscompares++; $display("[TB] FAIL t4_dirty_wb: got n=%0d we=%b addr=%h expected 2/1/ff", obsNTx, obsTxWe[0], obsTxAddr[0]); end
    nVectors++; if (obsTxLine[0] !== expWbLine || obsTxLine[0][31:0] !== 32'h5A5A5A5A) begin nMiscompares++; $display("[TB] FAIL t4_wb_data: got %h expected %h", obsTxLine[0], expWbLine); end
    nVectors++; if (bus.hit_count !== 4'(sat(refHits)) || bus.miss_count !== 4'(sat(refMisses))) begin nMiscompares++; $display("[TB] FAIL t4_counters: got %0d/%0d expected %0d/%0d", bus.hit_count, bus.miss_count, sat(refHits), sat(refMisses)); end
  endtask

  task automatic test_reset_mid_refill();
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 10'h085; bus.mem_ready = 1'b0;
    @(negedge clk);
    nVectors++; if (bus.stall !== 1'b1) begin nMiscompares++; $display("[TB] FAIL t5_miss_stall: got %b expected 1", bus.stall); end
    @(posedge clk); #1;
    @(negedge clk);
    nVectors++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h21) begin nMiscompares++; $display("[TB] FAIL t5_in_refill: got req=%b we=%b addr=%h expected 1/0/21", bus.mem_req, bus.mem_we, bus.mem_addr); end
    @(posedge clk); #1;
    RST = 1'b1;
    @(negedge clk);
    nVectors++; if (bus.stall !== 1'b0 || bus.cpu_rdata !== 32'h0) begin nMiscompares++; $display("[TB] FAIL t5_rst_outputs: got stall=%b rdata=%h expected 0/0", bus.stall, bus.cpu_rdata); end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    nVectors++; if (bus.mem_req !== 1'b0 || bus.hit_count !== 4'd0 || bus.miss_count !== 4'd0) begin nMiscompares++; $display("[TB] FAIL t5_after_rst: got req=%b hits=%0d misses=%0d expected 0/0/0", bus.mem_req, bus.hit_count, bus.miss_count); end
    @(posedge clk); #1;
    RST = 1'b0;
    refReset();
    refAccess(1, 0, 10'h085, '0);
    applyStimulus(1, 0, 10'h085, '0, 1);
    nVectors++; if (obsFirstStall !== 1'b1 || obsNTx !== 1 || obsTxAddr[0] !== 8'h21) begin nMiscompares++; $display("[TB] FAIL t5_post_miss: got stall=%b n=%0d addr=%h expected 1/1/21", obsFirstStall, obsNTx, obsTxAddr[0]); end
    nVectors++; if (obsRdata !== expRdata || bus.miss_count !== 4'd1) begin nMiscompares++; $display("[TB] FAIL t5_post_data: got %h/%0d expected %h/1", obsRdata, bus.miss_count, expRdata); end
  endtask

  task automatic test_saturation_and_rdwr();
    logic [31:0] wval;
    logic [9:0]  a;
    for (int i = 0; i < 20; i++) begin
      a = 10'h084 + 10'(i % 4);
      refAccess(1, 0, a, '0);
      applyStimulus(1, 0, a, '0, 0);
      nVectors++; if (bus.hit_count !== 4'(sat(refHits)) || obsRdata !== expRdata) begin nMiscompares++; $display("[TB] FAIL t6_sat_%0d: got %0d/%h expected %0d/%h", i, bus.hit_count, obsRdata, sat(refHits), expRdata); end
    end
    nVectors++; if (bus.hit_count !== 4'd15) begin nMiscompares++; $display("[TB] FAIL t6_saturated: got %0d expected 15", bus.hit_count); end
    wval = $urandom;
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 10'h086; bus.cpu_wdata = wval;
    @(negedge clk);
    nVectors++; if (bus.cpu_rdata !== 32'h0 || bus.stall !== 1'b0) begin nMiscompares++; $display("[TB] FAIL t6_rdwr: got rdata=%h stall=%b expected 0/0", bus.cpu_rdata, bus.stall); end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    refAccess(1, 1, 10'h086, wval);
    refAccess(1, 0, 10'h086, '0);
    applyStimulus(1, 0, 10'h086, '0, 0);
    nVectors++; if (obsRdata !== wval) begin nMiscompares++; $display("[TB] FAIL t6_rdwr_store: got %h expected %h", obsRdata, wval); end
  endtask

  task automatic test_random();
    bit rd, wr;
    int sel, d, nExp, rfSlot, idx;
    logic [9:0]  a;
    logic [31:0] wv;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      case ($urandom_range(0, 3))
        0: idx = 0;
        1: idx = 1;
        2: idx = 31;
        default: idx = $urandom_range(0, 31);
      endcase
      a  = 10'($urandom_range(0, 7) * 128 + idx * 4 + $urandom_range(0, 3));
      wv = $urandom;
      d  = $urandom_range(0, 3);
      refAccess(rd, wr, a, wv);
      applyStimulus(rd, wr, a, wv, d);
      nExp = int'(expMiss) + int'(expWb);
      rfSlot = expWb ? 1 : 0;
      nVectors++; if (obsTimeout || obsFirstStall !== expMiss) begin nMiscompares++; $display("[TB] FAIL rnd%0d_stall: got stall=%b timeout=%b expected %b/0", n, obsFirstStall, obsTimeout, expMiss); end
      nVectors++; if (obsNTx !== nExp) begin nMiscompares++; $display("[TB] FAIL rnd%0d_ntx: got %0d expected %0d", n, obsNTx, nExp); end
      if (expWb) begin
        nVectors++; if (obsTxWe[0] !== 1'b1 || obsTxAddr[0] !== 8'(expWbAddr) || obsTxLine[0] !== expWbLine) begin nMiscompares++; $display("[TB] FAIL rnd%0d_wb: got %b/%h/%h expected 1/%h/%h", n, obsTxWe[0], obsTxAddr[0], obsTxLine[0], 8'(expWbAddr), expWbLine); end
      end
      if (expMiss) begin
        nVectors++; if (obsTxWe[rfSlot] !== 1'b0 || obsTxAddr[rfSlot] !== 8'(expRfAddr)) begin nMiscompares++; $display("[TB] FAIL rnd%0d_refill: got %b/%h expected 0/%h", n, obsTxWe[rfSlot], obsTxAddr[rfSlot], 8'(expRfAddr)); end
      end
      nVectors++; if (obsRdata !== expRdata) begin nMiscompares++; $display("[TB] FAIL rnd%0d_rdata: got %h expected %h", n, obsRdata, expRdata); end
      nVectors++; if (obsCycles !== (expMiss ? (expWb ? 2*d + 4 : d + 3) : 1)) begin nMiscompares++; $display("[TB] FAIL rnd%0d_latency: got %0d cycles", n, obsCycles); end
      nVectors++; if (bus.hit_count !== 4'(sat(refHits)) || bus.miss_count !== 4'(sat(refMisses))) begin nMiscompares++; $display("[TB] FAIL rnd%0d_counters: got %0d/%0d expected %0d/%0d", n, bus.hit_count, bus.miss_count, sat(refHits), sat(refMisses)); end
    end
  endtask

  initial begin
    for (int i = 0; i < NMEM; i++) begin
      for (int w = 0; w < 4; w++) begin
        refMem[i][w] = $urandom;
        memLines[i][w*32 +: 32] = refMem[i][w];
      end
    end
    test_reset();
    test_clean_read_miss();
    test_read_hits();
    test_dirty_eviction();
    test_write_allocate_top_index();
    test_reset_mid_refill();
    test_saturation_and_rdwr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end
endmodule
